// File: rtl/timetag_pkg.sv
// Shared definitions for the timetagger-to-FT2232 record link.
// Holds the default record geometry, the FT245 strobe timing defaults and
// the link FSM state encoding. There are no ports; other files import this
// package with import timetag_pkg::*.
package timetag_pkg;

  localparam int REC_BYTES_DEF = 6;
  localparam int REC_W_DEF     = 8 * REC_BYTES_DEF;
  localparam int FIFO_AW_DEF   = 4;
  localparam int WR_CYCLES_DEF = 3;
  localparam int RD_CYCLES_DEF = 4;
  localparam int SI_IDLE_DEF   = 1023;
  // Cycles spent after a read so the FT2232 can raise nrxf and the new
  // level can pass through the synchronizer before arbitration looks at it.
  localparam int RECOV_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_SETUP,
    ST_W_STROBE,
    ST_W_HOLD,
    ST_R_STROBE,
    ST_R_RECOV,
    ST_SI
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rec_fifo.sv
// Synchronous first-word-fall-through record FIFO, W bits x 2**AW entries.
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset, empties the FIFO
//   wr_en_i    push wr_data_i (ignored while full)
//   wr_data_i  record to store
//   rd_en_i    pop the head record (ignored while empty)
//   rd_data_o  head record, valid whenever empty_o is low
//   full_o     no free entry
//   empty_o    no stored entry
// The storage array is read through a register. The register is loaded
// with the entry the head pointer will point at after this edge, so the
// head is always presented without an extra pop cycle. A write landing in
// exactly that slot is forwarded, since the array read sees the old word.
module rec_fifo
  import timetag_pkg::*;
#(
  parameter int W  = REC_W_DEF,
  parameter int AW = FIFO_AW_DEF
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          do_wr, do_rd;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign rd_data_o = rd_data_q;

  always_comb begin
    do_wr    = wr_en_i && !full_o;
    do_rd    = rd_en_i && !empty_o;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rd_data_d = (do_wr && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem[rd_ptr_d];
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
    rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ft245_record_link.sv
// Buffers timestamp records and streams them MSB byte first to an FT2232
// in 245 async-FIFO mode; also reads host command bytes from the FT2232.
// The bidirectional bus tristate lives in the level above this block.
// Ports:
//   clk_i, reset_i       system clock, synchronous active-high reset
//   rec_i, rec_valid_i   incoming record and strobe (no backpressure)
//   drop_cnt_o           records lost to a full FIFO, saturating
//   nrxf_i, ntxe_i       FT2232 rx-available / tx-space flags (active low, async)
//   nrd_o, wr_o, si_o    FT2232 read strobe (low), write strobe, send-immediate
//   d_i, d_o, d_oe_o     bus input, bus output, bus drive enable
//   cmd_o, cmd_valid_o   received host byte and its one-cycle strobe
// Build option: define FT_SI_FLUSH_EN to issue SEND_IMMEDIATE after SI_IDLE
// idle cycles with an empty FIFO; otherwise si_o is tied low.
module ft245_record_link
  import timetag_pkg::*;
#(
  parameter int REC_BYTES = REC_BYTES_DEF,
  parameter int FIFO_AW   = FIFO_AW_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF,
  parameter int RD_CYCLES = RD_CYCLES_DEF
`ifdef FT_SI_FLUSH_EN
  ,
  parameter int SI_IDLE   = SI_IDLE_DEF
`endif
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [8*REC_BYTES-1:0] rec_i,
  input  logic                   rec_valid_i,
  output logic [15:0]            drop_cnt_o,
  input  logic                   nrxf_i,
  input  logic                   ntxe_i,
  output logic                   nrd_o,
  output logic                   wr_o,
  output logic                   si_o,
  input  logic [7:0]             d_i,
  output logic [7:0]             d_o,
  output logic                   d_oe_o,
  output logic [7:0]             cmd_o,
  output logic                   cmd_valid_o
);

  localparam int REC_W = 8 * REC_BYTES;
  localparam int CNT_W = $clog2(max2(max2(WR_CYCLES, RD_CYCLES), RECOV_CYCLES) + 1);
  localparam int IDX_W = (REC_BYTES > 1) ? $clog2(REC_BYTES) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [REC_W-1:0]   rec_q, rec_d, rec_shift;
  logic               last_wr_q, last_wr_d;
  logic [1:0]         ntxe_sync_q, ntxe_sync_d;
  logic [1:0]         nrxf_sync_q, nrxf_sync_d;
  logic               nrd_q, nrd_d, wr_q, wr_d, d_oe_q, d_oe_d;
  logic [7:0]         d_o_q, d_o_d, cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [15:0]        drop_q, drop_d;
  logic               ntxe_s, nrxf_s, wr_elig, rd_elig;
  logic               fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [REC_W-1:0]   fifo_dout;
`ifdef FT_SI_FLUSH_EN
  localparam int SI_W = $clog2(SI_IDLE + 1);
  logic [SI_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic               sent_q, sent_d, si_q, si_d;
`endif

  rec_fifo #(.W(REC_W), .AW(FIFO_AW)) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (fifo_wr),
    .wr_data_i (rec_i),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign ntxe_s    = ntxe_sync_q[1];
  assign nrxf_s    = nrxf_sync_q[1];
  assign wr_elig   = !fifo_empty && !ntxe_s;
  assign rd_elig   = !nrxf_s;
  // Full is checked before any same-cycle pop, so a record arriving while
  // full is dropped even if the FSM frees a slot on this edge.
  assign fifo_wr   = rec_valid_i && !fifo_full;
  assign rec_shift = rec_q << 8;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rec_d       = rec_q;
    last_wr_d   = last_wr_q;
    nrd_d       = nrd_q;
    wr_d        = wr_q;
    d_oe_d      = d_oe_q;
    d_o_d       = d_o_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    drop_d      = drop_q;
    fifo_rd     = 1'b0;
    ntxe_sync_d = {ntxe_sync_q[0], ntxe_i};
    nrxf_sync_d = {nrxf_sync_q[0], nrxf_i};
`ifdef FT_SI_FLUSH_EN
    idle_cnt_d  = idle_cnt_q;
    sent_d      = sent_q;
    si_d        = si_q;
`endif

    if (rec_valid_i && fifo_full && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    case (state_q)
      ST_IDLE: begin
        // Write wins unless a read is also waiting and write went last.
        if (wr_elig && (!rd_elig || !last_wr_q)) begin
          fifo_rd   = 1'b1;
          rec_d     = fifo_dout;
          idx_d     = IDX_W'(REC_BYTES - 1);
          d_oe_d    = 1'b1;
          d_o_d     = fifo_dout[REC_W-1 -: 8];
          last_wr_d = 1'b1;
          state_d   = ST_W_SETUP;
`ifdef FT_SI_FLUSH_EN
          idle_cnt_d = '0;
          sent_d     = 1'b1;
`endif
        end else if (rd_elig) begin
          nrd_d     = 1'b0;
          cnt_d     = '0;
          last_wr_d = 1'b0;
          state_d   = ST_R_STROBE;
`ifdef FT_SI_FLUSH_EN
          idle_cnt_d = '0;
`endif
        end
`ifdef FT_SI_FLUSH_EN
        else if (sent_q && fifo_empty) begin
          if ((idle_cnt_q == SI_W'(SI_IDLE)) && !ntxe_s) begin
            si_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_SI;
          end else if (idle_cnt_q != SI_W'(SI_IDLE)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
`endif
      end
      ST_W_SETUP: begin
        wr_d    = 1'b1;
        cnt_d   = '0;
        state_d = ST_W_STROBE;
      end
      ST_W_STROBE: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          wr_d    = 1'b0;
          state_d = ST_W_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_W_HOLD: begin
        // Once started, a record only waits here for tx space; reads are
        // never slotted in between its bytes.
        if (idx_q == '0) begin
          d_oe_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (!ntxe_s) begin
          idx_d   = idx_q - 1'b1;
          rec_d   = rec_shift;
          d_o_d   = rec_shift[REC_W-1 -: 8];
          state_d = ST_W_SETUP;
        end
      end
      ST_R_STROBE: begin
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          cmd_d       = d_i;
          cmd_valid_d = 1'b1;
          nrd_d       = 1'b1;
          cnt_d       = '0;
          state_d     = ST_R_RECOV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_R_RECOV: begin
        if (cnt_q == CNT_W'(RECOV_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef FT_SI_FLUSH_EN
      ST_SI: begin
        if (cnt_q == CNT_W'(WR_CYCLES - 1)) begin
          si_d       = 1'b0;
          idle_cnt_d = '0;
          sent_d     = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      rec_q       <= '0;
      last_wr_q   <= 1'b0;
      ntxe_sync_q <= 2'b11;
      nrxf_sync_q <= 2'b11;
      nrd_q       <= 1'b1;
      wr_q        <= 1'b0;
      d_oe_q      <= 1'b0;
      d_o_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rec_q       <= rec_d;
      last_wr_q   <= last_wr_d;
      ntxe_sync_q <= ntxe_sync_d;
      nrxf_sync_q <= nrxf_sync_d;
      nrd_q       <= nrd_d;
      wr_q        <= wr_d;
      d_oe_q      <= d_oe_d;
      d_o_q       <= d_o_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      drop_q      <= drop_d;
    end
  end

`ifdef FT_SI_FLUSH_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idle_cnt_q <= '0;
      sent_q     <= 1'b0;
      si_q       <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      sent_q     <= sent_d;
      si_q       <= si_d;
    end
  end
  assign si_o = si_q;
`else
  assign si_o = 1'b0;
`endif

  assign nrd_o       = nrd_q;
  assign wr_o        = wr_q;
  assign d_oe_o      = d_oe_q;
  assign d_o         = d_o_q;
  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_ft245_record_link.sv
// Bench for ft245_record_link. Stimulus pushes expected tx bytes and host
// command bytes into queues; a negedge monitor pops them whenever the DUT
// completes a write strobe or pulses cmd_valid_o. A small host model feeds
// d_i/nrxf_i from its own byte queue.
module tb_ft245_record_link;

  localparam int WR_CYC = 3;
  localparam int RD_CYC = 4;
  localparam int DEPTH  = 16;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [47:0] rec_i = '0;
  logic        rec_valid_i = 1'b0;
  logic [15:0] drop_cnt_o;
  logic        nrxf_i = 1'b1;
  logic        ntxe_i = 1'b1;
  logic        nrd_o, wr_o, si_o;
  logic [7:0]  d_i = 8'h00;
  logic [7:0]  d_o;
  logic        d_oe_o;
  logic [7:0]  cmd_o;
  logic        cmd_valid_o;

  ft245_record_link dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .rec_i       (rec_i),
    .rec_valid_i (rec_valid_i),
    .drop_cnt_o  (drop_cnt_o),
    .nrxf_i      (nrxf_i),
    .ntxe_i      (ntxe_i),
    .nrd_o       (nrd_o),
    .wr_o        (wr_o),
    .si_o        (si_o),
    .d_i         (d_i),
    .d_o         (d_o),
    .d_oe_o      (d_oe_o),
    .cmd_o       (cmd_o),
    .cmd_valid_o (cmd_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_cmds[$];
  logic [7:0] host_q[$];
  logic [7:0] svc_log[$];
  int   bytes_seen = 0;
  bit   host_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         wr_run = 0, rd_run = 0;
  bit         overlap = 1'b0;
  logic       prev_doe = 1'b0;
  logic [7:0] mon_e;

  always @(negedge clk_i) begin
    if (reset_i) begin
      wr_run = 0; rd_run = 0; overlap = 1'b0; prev_doe = 1'b0;
    end else begin
      if (wr_o) begin
        wr_run++;
      end else if (wr_run > 0) begin
        check("wr_width", 32'(wr_run), 32'(WR_CYC));
        if (exp_bytes.size() == 0) begin
          checks++; fails++;
          $display("FAIL tx_byte: got unexpected byte %0h, expected none", d_o);
        end else begin
          mon_e = exp_bytes.pop_front();
          check("tx_byte", {23'd0, d_oe_o, d_o}, {23'd0, 1'b1, mon_e});
        end
        $display("tx byte %02h", d_o);
        bytes_seen++;
        wr_run = 0;
      end
      if (d_oe_o && !prev_doe) svc_log.push_back("W");
      prev_doe = d_oe_o;
      if (!nrd_o) begin
        if (rd_run == 0) svc_log.push_back("R");
        rd_run++;
        if (d_oe_o || wr_o) overlap = 1'b1;
      end else if (rd_run > 0) begin
        check("nrd_width", 32'(rd_run), 32'(RD_CYC));
        check("rd_bus_conflict", 32'(overlap), 32'd0);
        rd_run = 0; overlap = 1'b0;
      end
      if (cmd_valid_o) begin
        if (exp_cmds.size() == 0) begin
          checks++; fails++;
          $display("FAIL cmd: got unexpected cmd %0h, expected none", cmd_o);
        end else begin
          mon_e = exp_cmds.pop_front();
          check("cmd", 32'(cmd_o), 32'(mon_e));
        end
        $display("rx cmd %02h", cmd_o);
      end
    end
  end

  // ---------------- FT2232 host side model ----------------
  always @(posedge nrd_o) begin
    if (host_armed && host_q.size() > 0) begin
      void'(host_q.pop_front());
      nrxf_i = (host_q.size() == 0);
      if (host_q.size() > 0) d_i = host_q[0];
    end
  end

  task automatic host_push(input logic [7:0] b);
    host_q.push_back(b);
    exp_cmds.push_back(b);
    d_i    = host_q[0];
    nrxf_i = 1'b0;
  endtask

  task automatic send_rec(input logic [47:0] r);
    rec_i       = r;
    rec_valid_i = 1'b1;
    for (int k = 5; k >= 0; k--) exp_bytes.push_back(r[k*8 +: 8]);
    tick(1);
    rec_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_bytes.size() > 0 || exp_cmds.size() > 0) && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 32'(exp_bytes.size() + exp_cmds.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int          n, base, model_occ, model_drops;
  logic [63:0] rnd;
  bit          rec_done, host_done;

  initial begin
    reset_i = 1'b1;
    tick(3);
    @(negedge clk_i);
    check("rst_nrd", 32'(nrd_o), 32'd1);
    check("rst_wr", 32'(wr_o), 32'd0);
    check("rst_si", 32'(si_o), 32'd0);
    check("rst_doe", 32'(d_oe_o), 32'd0);
    check("rst_d_o", 32'(d_o), 32'd0);
    check("rst_cmd", 32'(cmd_o), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);
    tick(1);
    reset_i    = 1'b0;
    host_armed = 1'b1;
    tick(2);

    // One record, continuous tx space.
    ntxe_i = 1'b0;
    send_rec(48'h0123456789AB);
    wait_drain("t1_drain", 400);
    tick(1);
    check("t1_doe_released", 32'(d_oe_o), 32'd0);
    tick(4);

    // Tx space withdrawn during the second byte; bus must park on 23.
    base = bytes_seen;
    send_rec(48'h0123456789AB);
    n = 0;
    while (!(bytes_seen == base + 1 && wr_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("t2_at_byte2", 32'(bytes_seen - base), 32'd1);
    @(posedge clk_i); #1;
    ntxe_i = 1'b1;
    tick(4);
    repeat (18) begin
      @(negedge clk_i);
      check("t2_stall_bus", {22'd0, wr_o, d_oe_o, d_o}, {22'd0, 1'b0, 1'b1, 8'h23});
    end
    @(posedge clk_i); #1;
    ntxe_i = 1'b0;
    wait_drain("t2_drain", 400);
    tick(4);

    // Host byte with an empty record FIFO.
    host_push(8'h5A);
    wait_drain("t3_read", 200);
    tick(2);
    check("t3_nrd_idle", 32'(nrd_o), 32'd1);

    // Overflow: 40 back-to-back records with no tx space.
    ntxe_i = 1'b1;
    tick(4);
    model_occ = 0;
    model_drops = 0;
    for (int i = 0; i < 40; i++) begin
      rnd         = {$urandom(), $urandom()};
      rec_i       = {i[15:0], rnd[31:0]};
      rec_valid_i = 1'b1;
      if (model_occ < DEPTH) begin
        for (int k = 5; k >= 0; k--) exp_bytes.push_back(rec_i[k*8 +: 8]);
        model_occ++;
      end else begin
        model_drops++;
      end
      tick(1);
    end
    rec_valid_i = 1'b0;
    tick(1);
    check("t4_drop_cnt", 32'(drop_cnt_o), 32'(model_drops));
    ntxe_i = 1'b0;
    wait_drain("t4_drain", 3000);
    tick(4);

    // Fairness: both sides eligible from the same cycle after reset.
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    tick(1);
    check("t5_drop_cleared", 32'(drop_cnt_o), 32'd0);
    ntxe_i = 1'b1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom(), $urandom()};
      send_rec(rnd[47:0]);
    end
    tick(2);
    svc_log.delete();
    for (int i = 0; i < 4; i++) host_push(8'(8'hC0 + i));
    ntxe_i = 1'b0;
    wait_drain("t5_drain", 2000);
    tick(4);
    check("t5_svc_count", 32'(svc_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t5_svc_order", (i < svc_log.size()) ? 32'(svc_log[i]) : 32'd0,
            (i % 2 == 0) ? 32'("W") : 32'("R"));
    end

    // Reset in the middle of a write strobe.
    ntxe_i = 1'b1;
    tick(3);
    send_rec(48'hA1A2A3A4A5A6);
    send_rec(48'hB1B2B3B4B5B6);
    ntxe_i = 1'b0;
    n = 0;
    while (!wr_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_strobe_seen", 32'(wr_o), 32'd1);
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    exp_bytes.delete();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("t6_wr_after_rst", 32'(wr_o), 32'd0);
    check("t6_doe_after_rst", 32'(d_oe_o), 32'd0);
    base = bytes_seen;
    tick(60);
    check("t6_fifo_empty", 32'(bytes_seen - base), 32'd0);

    // Random mix of records, host bytes and tx-space toggling.
    rec_done  = 1'b0;
    host_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          tick($urandom_range(0, 30));
          n = 0;
          while (exp_bytes.size() > 48 && n < 2000) begin
            tick(1);
            n++;
          end
          rnd = {$urandom(), $urandom()};
          send_rec(rnd[47:0]);
        end
        rec_done = 1'b1;
      end
      begin
        for (int j = 0; j < 12; j++) begin
          tick($urandom_range(5, 80));
          host_push(8'($urandom_range(0, 255)));
        end
        host_done = 1'b1;
      end
      begin
        while (!(rec_done && host_done)) begin
          tick($urandom_range(1, 15));
          ntxe_i = ($urandom_range(0, 3) == 0);
        end
        ntxe_i = 1'b0;
      end
    join
    wait_drain("t7_drain", 5000);
    tick(4);
    check("t7_si_low", 32'(si_o), 32'd0);
    check("t7_no_drops", 32'(drop_cnt_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
